execute_muldiv: RTL and testbench
=================================

Name: execute_muldiv

Overview:
Iterative multiply/divide unit that sits beside the ALU in the execute stage of the MIPS pipeline.
- Its operands come from the execute-stage forwarding muxes.
- It owns the architectural HI/LO registers.
- It raises a stall to freeze IF/ID/EX while a MULT/MULTU/DIV/DIVU is in progress.
- Width is parametrised, so the same unit serves the 32-bit core and reduced-width test instances.

Parameters:
LEN, 32, datapath width (even, ≥4)
NB_CNT, $clog2(LEN)+1, iteration counter width

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-low
in_valid  input  1  instruction in EX targets this unit
in_op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (= NOP)
in_a  input  LEN  forwarded rs value (multiplicand / dividend / MTHI-MTLO source)
in_b  input  LEN  forwarded rt value (multiplier / divisor)
flush  input  1  kill current EX instruction and any operation in progress
out_stall  output  1  hold IF/ID/EX pipeline registers
out_done  output  1  one-cycle pulse, HI/LO just updated by mul/div
out_hi  output  LEN  HI register
out_lo  output  LEN  LO register
out_busy  output  1  state ≠ IDLE

Behaviour:
- Reset (async, any time including mid-operation):
  - state=IDLE; out_hi, out_lo, out_done, counter and working registers = 0.
  - out_stall=0, out_busy=0 while reset low.
- FSM states: IDLE, ITER, FIX.
- accept = state==IDLE & in_valid & op∈{1..4} & !out_done & !flush.
- out_done masks acceptance so the stalled instruction, still in EX in the done cycle, is not restarted.
- IDLE→ITER on accept:
  - Latch |in_a|, |in_b| for signed ops; raw values for unsigned ops.
  - Latch result-sign flags.
  - counter=LEN.
- ITER:
  - One radix-2 step per cycle, counter decrements.
  - Multiply: shift-add into a 2·LEN accumulator.
  - Divide: restoring shift-subtract; quotient bit set when partial remainder ≥ divisor (LEN+1-bit compare).
  - ITER→FIX when counter reaches 1, after exactly LEN steps.
- FIX (one cycle): apply two's-complement sign correction, then go to IDLE.
  - MULT: product negated if signs of in_a and in_b differ.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Quotient truncates toward zero.
- FIX→IDLE edge: write HI/LO, then out_done=1 for exactly the next cycle.
  - Multiply: HI=upper half, LO=lower half.
  - Divide: LO=quotient, HI=remainder.
- out_stall = accept | (state≠IDLE); combinational, asserted in the issue cycle.
- Timing for an issue at cycle T:
  - out_stall high T..T+LEN+1 (LEN+2 cycles).
  - HI/LO valid and out_done=1 at T+LEN+2, with out_stall=0 that cycle.
  - A mul/div in EX at T+LEN+3 is accepted normally (back-to-back supported).
- Divide by zero:
  - No trap; same latency.
  - Result: LO = all ones, HI = dividend (original signed value for DIV).
- DIV of most-negative by -1: LO = most-negative, HI = 0; no exception.
- MTHI/MTLO: when in_valid & state==IDLE & !flush, write in_a to HI/LO at the clock edge.
  - No stall, no out_done.
  - These ops cannot reach the unit while busy because the pipeline is stalled; if presented while not IDLE, ignore them.
- flush has priority over everything except reset:
  - Blocks accept and MTHI/MTLO writes.
  - If in ITER/FIX, abort to IDLE next edge; HI/LO unchanged, out_done stays 0.
  - out_stall drops combinationally in the flush cycle.
- in_a/in_b are sampled only at accept; later changes are ignored.
- NOP and reserved ops have no effect.

Test Plan:
1. LEN=32, MULT a=7, b=0xFFFFFFFD (-3) → out_stall high 34 cycles; out_done then out_hi=0xFFFFFFFF, out_lo=0xFFFFFFEB.
2. MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; immediately follow with MULT 2×3 → accepted the cycle after out_done, lo=6, hi=0.
3. DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0; DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
4. Hold in_valid with DIVU 100/7 for the whole stall → exactly one out_done pulse, lo=14, hi=2, no restart; MTLO 0x1234 next cycle → out_lo=0x1234 with no stall.
5. Preload hi=0xAAAA via MTHI; start MULT 3×3, assert flush at cycle T+10 → IDLE next edge, out_stall low, hi still 0xAAAA, no out_done; reset low at T+5 of a new DIV → all outputs 0 immediately.
6. LEN=8 instance: MULT 0x80×0x80 → hi=0x40, lo=0x00, stall 10 cycles; DIV 0x80/0xFF → lo=0x80, hi=0.

Source files
------------

// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative radix-2 multiply/divide unit beside the execute-stage ALU.
// Owns the architectural HI/LO registers, freezes IF/ID/EX while a MULT/MULTU/DIV/DIVU
// runs (LEN+2 cycles from issue), then pulses out_done as HI/LO show the new result.
module execute_muldiv #(
    parameter int LEN    = 32,
    parameter int NB_CNT = $clog2(LEN) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [2:0]     in_op,
    input  logic [LEN-1:0] in_a,
    input  logic [LEN-1:0] in_b,
    input  logic           flush,
    output logic           out_stall,
    output logic           out_done,
    output logic [LEN-1:0] out_hi,
    output logic [LEN-1:0] out_lo,
    output logic           out_busy
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t            state, state_next;
    logic [NB_CNT-1:0] count;
    // mul: {accumulator high, multiplier shifting out / product low}
    // div: {partial remainder, dividend shifting out / quotient shifting in}
    logic [2*LEN-1:0]  work;
    logic [LEN-1:0]    opnd;      // multiplicand or divisor magnitude
    logic              is_div;
    logic              neg_main;  // negate product (mul) or quotient (div)
    logic              neg_rem;   // negate remainder (div only)

    logic              is_muldiv, op_signed, op_div, accept;
    logic [LEN-1:0]    a_mag, b_mag;
    logic [2*LEN-1:0]  work_step;
    logic [2*LEN-1:0]  prod_fix;
    logic [LEN-1:0]    hi_fix, lo_fix;

    // Issue decode. out_done masks acceptance: the instruction that was stalled is
    // still sitting in EX during the done cycle and must not be started again.
    assign is_muldiv = (in_op == OP_MULT) || (in_op == OP_MULTU) ||
                       (in_op == OP_DIV)  || (in_op == OP_DIVU);
    assign op_signed = (in_op == OP_MULT) || (in_op == OP_DIV);
    assign op_div    = (in_op == OP_DIV)  || (in_op == OP_DIVU);
    assign accept    = reset && (state == IDLE) && in_valid && is_muldiv && !out_done && !flush;
    assign a_mag     = (op_signed && in_a[LEN-1]) ? -in_a : in_a;
    assign b_mag     = (op_signed && in_b[LEN-1]) ? -in_b : in_b;

    assign out_stall = reset && !flush && (accept || (state != IDLE));
    assign out_busy  = (state != IDLE);

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        logic [LEN:0] mul_sum;
        logic [LEN:0] div_shift;
        logic [LEN:0] div_diff;
        logic         div_ge;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        work_step = work;
        mul_sum   = {1'b0, work[2*LEN-1:LEN]} + (work[0] ? {1'b0, opnd} : '0);
        div_shift = work[2*LEN-1:LEN-1];
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});
        if (is_div)
            work_step = {(div_ge ? div_diff[LEN-1:0] : div_shift[LEN-1:0]), work[LEN-2:0], div_ge};
        else
            work_step = {mul_sum, work[LEN-1:1]};
    end

    // Two's-complement sign correction applied in FIX
    always_comb begin
        prod_fix = neg_main ? -work : work;
        hi_fix   = prod_fix[2*LEN-1:LEN];
        lo_fix   = prod_fix[LEN-1:0];
        if (is_div) begin
            lo_fix = neg_main ? -work[LEN-1:0] : work[LEN-1:0];
            hi_fix = neg_rem ? -work[2*LEN-1:LEN] : work[2*LEN-1:LEN];
        end
    end

    // Next-state logic; flush aborts any operation in progress
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ITER;
            ITER: begin
                if (flush)                       state_next = IDLE;
                else if (count == NB_CNT'(1))    state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Operand capture, iteration, HI/LO writes and the one-cycle done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            work     <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            out_hi   <= '0;
            out_lo   <= '0;
            out_done <= 1'b0;
        end else begin
            out_done <= (state == FIX) && !flush;
            if (accept) begin
                count    <= NB_CNT'(LEN);
                work     <= {{LEN{1'b0}}, (op_div ? a_mag : b_mag)};
                opnd     <= op_div ? b_mag : a_mag;
                is_div   <= op_div;
                // A zero divisor yields an all-ones quotient regardless of signs.
                neg_main <= op_signed && (in_a[LEN-1] ^ in_b[LEN-1]) && !(op_div && (in_b == '0));
                neg_rem  <= op_signed && in_a[LEN-1];
            end else if ((state == ITER) && !flush) begin
                work  <= work_step;
                count <= count - NB_CNT'(1);
            end
            if ((state == FIX) && !flush) begin
                out_hi <= hi_fix;
                out_lo <= lo_fix;
            end else if ((state == IDLE) && in_valid && !flush) begin
                if (in_op == OP_MTHI)      out_hi <= in_a;
                else if (in_op == OP_MTLO) out_lo <= in_a;
            end
        end
    end
endmodule

// File: tb/tb_execute_muldiv.sv
// Testbench for execute_muldiv: directed scenarios on a 32-bit and an 8-bit instance,
// then randomized operations checked against a plain-arithmetic HI/LO model.
module tb_execute_muldiv;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        valid32, flush32, stall32, done32, busy32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        valid8, flush8, stall8, done8, busy8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int n_checks = 0;
    int n_pass   = 0;

    execute_muldiv #(.LEN(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(valid32), .in_op(op32), .in_a(a32), .in_b(b32),
        .flush(flush32), .out_stall(stall32), .out_done(done32), .out_hi(hi32), .out_lo(lo32),
        .out_busy(busy32)
    );

    execute_muldiv #(.LEN(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(valid8), .in_op(op8), .in_a(a8), .in_b(b8),
        .flush(flush8), .out_stall(stall8), .out_done(done8), .out_hi(hi8), .out_lo(lo8),
        .out_busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sm, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic fl);
        if (sm) begin
            valid8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0]; flush8 = fl;
        end else begin
            valid32 = v; op32 = op; a32 = a; b32 = b; flush32 = fl;
        end
    endtask

    function automatic logic        obs_stall(input bit sm); return sm ? stall8 : stall32; endfunction
    function automatic logic        obs_done(input bit sm);  return sm ? done8  : done32;  endfunction
    function automatic logic        obs_busy(input bit sm);  return sm ? busy8  : busy32;  endfunction
    function automatic logic [31:0] obs_hi(input bit sm);    return sm ? {24'd0, hi8} : hi32; endfunction
    function automatic logic [31:0] obs_lo(input bit sm);    return sm ? {24'd0, lo8} : lo32; endfunction

    // Architectural HI/LO effect of one instruction, computed with wide integer arithmetic.
    function automatic void ref_model(input int len, input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, inout logic [31:0] hi, inout logic [31:0] lo);
        logic [63:0] mask, ua, ub, prod;
        longint      sa, sb;
        mask = (64'd1 << len) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = a[len-1] ? longint'(ua) - (longint'(1) << len) : longint'(ua);
        sb   = b[len-1] ? longint'(ub) - (longint'(1) << len) : longint'(ub);
        case (op)
            3'd1, 3'd2: begin
                prod = (op == 3'd1) ? 64'(sa * sb) : ua * ub;
                hi   = 32'((prod >> len) & mask);
                lo   = 32'(prod & mask);
            end
            3'd3: begin
                if (sb == 0) begin lo = 32'(mask); hi = 32'(ua); end
                else begin lo = 32'(64'(sa / sb) & mask); hi = 32'(64'(sa % sb) & mask); end
            end
            3'd4: begin
                if (ub == 0) begin lo = 32'(mask); hi = 32'(ua); end
                else begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
            end
            3'd5: hi = 32'(ua);
            3'd6: lo = 32'(ua);
            default: ;
        endcase
    endfunction

    // Issue a mul/div in the current cycle, count stall cycles, check the done cycle.
    task automatic do_op(input bit sm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input string tag);
        int n;
        int len;
        len = sm ? 8 : 32;
        drive(sm, 1'b1, op, a, b, 1'b0);
        @(negedge clk);
        check({tag, " issue_done"}, 32'(obs_done(sm)), 32'd0);
        n = 0;
        while (obs_stall(sm) === 1'b1 && n < 200) begin
            n++;
            next_cycle();
            if (!hold) drive(sm, 1'b0, 3'd0, $urandom, $urandom, 1'b0);
            @(negedge clk);
        end
        check({tag, " stall_cycles"}, 32'(n), 32'(len + 2));
        check({tag, " done"}, 32'(obs_done(sm)), 32'd1);
        check({tag, " busy"}, 32'(obs_busy(sm)), 32'd0);
        check({tag, " hi"}, obs_hi(sm), exp_hi);
        check({tag, " lo"}, obs_lo(sm), exp_lo);
    endtask

    initial begin
        logic [31:0] mhi [2];
        logic [31:0] mlo [2];
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bit          sm;
        bit          seen_done;

        // Reset state: outputs zero and stall held low even with a mul/div presented
        reset = 1'b0;
        drive(0, 1'b1, 3'd1, 32'd5, 32'd6, 1'b0);
        drive(1, 1'b1, 3'd1, 32'd5, 32'd6, 1'b0);
        @(negedge clk);
        check("rst stall32", 32'(stall32), 32'd0);
        check("rst busy32", 32'(busy32), 32'd0);
        check("rst done32", 32'(done32), 32'd0);
        check("rst hi32", hi32, 32'd0);
        check("rst lo32", lo32, 32'd0);
        check("rst stall8", 32'(stall8), 32'd0);
        next_cycle();
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;

        // MULT 7 x -3, then MULTU max x max followed back-to-back by MULT 2 x 3
        next_cycle();
        do_op(0, 3'd1, 32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
        next_cycle();
        do_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        next_cycle();
        do_op(0, 3'd1, 32'd2, 32'd3, 0, 32'd0, 32'd6, "mult_b2b");

        // Signed divide, most-negative / -1, divide by zero
        next_cycle();
        do_op(0, 3'd3, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        next_cycle();
        do_op(0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0, 32'h8000_0000, "div_ovf");
        next_cycle();
        do_op(0, 3'd4, 32'd5, 32'd0, 0, 32'd5, 32'hFFFF_FFFF, "divu_zero");
        next_cycle();
        do_op(0, 3'd3, 32'hFFFF_FFF9, 32'd0, 0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero_neg");

        // in_valid held through the whole stall: one done pulse, no restart, then MTLO
        next_cycle();
        do_op(0, 3'd4, 32'd100, 32'd7, 1, 32'd2, 32'd14, "divu_hold");
        next_cycle();
        drive(0, 1'b1, 3'd6, 32'h1234, 32'd0, 1'b0);
        @(negedge clk);
        check("hold no_restart_stall", 32'(stall32), 32'd0);
        check("hold no_restart_busy", 32'(busy32), 32'd0);
        check("hold done_once", 32'(done32), 32'd0);
        next_cycle();
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("mtlo lo", lo32, 32'h1234);
        check("mtlo hi", hi32, 32'd2);

        // MTHI preload, MULT 3 x 3 flushed at T+10
        next_cycle();
        drive(0, 1'b1, 3'd5, 32'hAAAA, 32'd0, 1'b0);
        @(negedge clk);
        check("mthi stall", 32'(stall32), 32'd0);
        next_cycle();
        drive(0, 1'b1, 3'd1, 32'd3, 32'd3, 1'b0);
        @(negedge clk);
        check("mthi hi", hi32, 32'hAAAA);
        check("flush issue_stall", 32'(stall32), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            drive(0, (k == 10), 3'd1, 32'd3, 32'd3, (k == 10));
        end
        @(negedge clk);
        check("flush stall_drop", 32'(stall32), 32'd0);
        next_cycle();
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("flush busy", 32'(busy32), 32'd0);
        check("flush stall_after", 32'(stall32), 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done32 === 1'b1) seen_done = 1'b1;
            next_cycle();
        end
        check("flush no_done", 32'(seen_done), 32'd0);
        check("flush hi_kept", hi32, 32'hAAAA);
        check("flush lo_kept", lo32, 32'h1234);

        // Reset asserted five cycles into a DIV
        drive(0, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        end
        reset = 1'b0;
        #1;
        check("midrst hi", hi32, 32'd0);
        check("midrst lo", lo32, 32'd0);
        check("midrst done", 32'(done32), 32'd0);
        check("midrst stall", 32'(stall32), 32'd0);
        check("midrst busy", 32'(busy32), 32'd0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("midrst idle_after", 32'(busy32), 32'd0);

        // 8-bit instance: most-negative squared, most-negative / -1
        next_cycle();
        do_op(1, 3'd1, 32'h80, 32'h80, 0, 32'h40, 32'h00, "mult8_minsq");
        next_cycle();
        do_op(1, 3'd3, 32'h80, 32'hFF, 0, 32'h00, 32'h80, "div8_ovf");

        // Randomized mix against the model, both widths
        mhi[0] = 32'd0;  mlo[0] = 32'd0;
        mhi[1] = 32'd0;  mlo[1] = 32'h80;
        for (int i = 0; i < 40; i++) begin
            sm  = (i % 2) == 1;
            rop = 3'($urandom_range(0, 9) < 7 ? $urandom_range(1, 4) : $urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) begin
                ra = sm ? 32'h80 : 32'h8000_0000;
                rb = sm ? 32'hFF : 32'hFFFF_FFFF;
            end
            if (sm) begin ra = ra & 32'hFF; rb = rb & 32'hFF; end
            ref_model(sm ? 8 : 32, rop, ra, rb, mhi[sm], mlo[sm]);
            next_cycle();
            if (rop >= 3'd1 && rop <= 3'd4) begin
                do_op(sm, rop, ra, rb, 0, mhi[sm], mlo[sm], $sformatf("rand%0d op%0d", i, rop));
            end else begin
                drive(sm, 1'b1, rop, ra, rb, 1'b0);
                @(negedge clk);
                check($sformatf("rand%0d op%0d stall", i, rop), 32'(obs_stall(sm)), 32'd0);
                next_cycle();
                drive(sm, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
                @(negedge clk);
                check($sformatf("rand%0d op%0d hi", i, rop), obs_hi(sm), mhi[sm]);
                check($sformatf("rand%0d op%0d lo", i, rop), obs_lo(sm), mlo[sm]);
            end
        end
        next_cycle();
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
